// File: rtl/adsr_env_if.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_env_if
//  Brief    : Gate/time/NCO/level signal bundle between voice logic and adsr_env
//  Revision : 1.0  initial release
// ============================================================================
interface adsr_env_if #(
    parameter int W = 7
);
    logic         gate;
    logic [W-1:0] attack_time;
    logic [W-1:0] decay_time;
    logic [W-1:0] sustain_level;
    logic [W-1:0] release_time;
    logic [W-1:0] env_scale;
    logic         env_ovflow;
    logic         env_dv;
    logic [W-1:0] env_time;
    logic         nco_rst;
    logic [W-1:0] env_level;
    logic         env_level_dv;
    logic         env_active;

    modport master (
        output gate, attack_time, decay_time, sustain_level, release_time,
        output env_scale, env_ovflow, env_dv,
        input  env_time, nco_rst, env_level, env_level_dv, env_active
    );

    modport slave (
        input  gate, attack_time, decay_time, sustain_level, release_time,
        input  env_scale, env_ovflow, env_dv,
        output env_time, nco_rst, env_level, env_level_dv, env_active
    );
endinterface
`default_nettype wire

// File: rtl/adsr_env.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_env
//  Brief    : ADSR envelope sequencer driving an NCO ramp, one level per sample
//  Revision : 1.0  initial release
// ============================================================================
module adsr_env #(
    parameter int W = 7
) (
    input  wire logic  clk,
    input  wire logic  rst,
    adsr_env_if.slave  bus
);
    localparam logic [2:0]   c_IDLE    = 3'd0;
    localparam logic [2:0]   c_ATTACK  = 3'd1;
    localparam logic [2:0]   c_DECAY   = 3'd2;
    localparam logic [2:0]   c_SUSTAIN = 3'd3;
    localparam logic [2:0]   c_RELEASE = 3'd4;
    localparam int           c_W2      = 2 * W;
    localparam logic [W-1:0] c_MAX     = {W{1'b1}};

    logic         r_gate_q;
    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic         w_gate_move;
    logic         r_nco_rst;
    logic [W-1:0] r_level;
    logic [W-1:0] w_level_nxt;
    logic [W-1:0] r_rel_start;
    logic         r_level_dv;
    logic         w_rise;
    logic         w_fall;
    logic         w_dv;
    logic         w_seg_end;
    logic [W-1:0] w_dec_span;
    logic [c_W2-1:0] w_dec_prod;
    logic [c_W2-1:0] w_rel_prod;

    assign w_rise    = bus.gate & ~r_gate_q;
    assign w_fall    = ~bus.gate & r_gate_q;
    // The NCO is being restarted during the pulse cycle, so its strobe is stale.
    assign w_dv      = bus.env_dv & ~r_nco_rst;
    assign w_seg_end = w_dv & bus.env_ovflow;

    assign w_dec_span = c_MAX - bus.sustain_level;
    assign w_dec_prod = c_W2'(w_dec_span) * c_W2'(bus.env_scale);
    assign w_rel_prod = c_W2'(r_rel_start) * c_W2'(bus.env_scale);

    always_comb begin
        w_next_state = r_state;
        w_gate_move  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_rise) begin
                    w_next_state = c_ATTACK;
                    w_gate_move  = 1'b1;
                end
            end
            c_ATTACK: begin
                if (w_fall) begin
                    w_next_state = c_RELEASE;
                    w_gate_move  = 1'b1;
                end else if (w_seg_end) begin
                    w_next_state = c_DECAY;
                end
            end
            c_DECAY: begin
                if (w_fall) begin
                    w_next_state = c_RELEASE;
                    w_gate_move  = 1'b1;
                end else if (w_seg_end) begin
                    w_next_state = c_SUSTAIN;
                end
            end
            c_SUSTAIN: begin
                if (w_fall) begin
                    w_next_state = c_RELEASE;
                    w_gate_move  = 1'b1;
                end
            end
            c_RELEASE: begin
                if (w_rise) begin
                    w_next_state = c_ATTACK;
                    w_gate_move  = 1'b1;
                end else if (w_seg_end) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Segment end snaps to the exact target so rounding never leaves a residue.
    always_comb begin
        w_level_nxt = r_level;
        case (r_state)
            c_ATTACK:  w_level_nxt = bus.env_ovflow ? c_MAX : bus.env_scale;
            c_DECAY:   w_level_nxt = bus.env_ovflow ? bus.sustain_level
                                                    : c_MAX - w_dec_prod[c_W2-1:W];
            c_SUSTAIN: w_level_nxt = bus.sustain_level;
            c_RELEASE: w_level_nxt = bus.env_ovflow ? '0
                                                    : r_rel_start - w_rel_prod[c_W2-1:W];
            default:   w_level_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_q    <= 1'b0;
            r_state     <= c_IDLE;
            r_nco_rst   <= 1'b0;
            r_level     <= '0;
            r_rel_start <= '0;
            r_level_dv  <= 1'b0;
        end else begin
            r_gate_q   <= bus.gate;
            r_state    <= w_next_state;
            r_nco_rst  <= (w_next_state != r_state) &&
                          ((w_next_state == c_ATTACK) || (w_next_state == c_DECAY) ||
                           (w_next_state == c_RELEASE));
            r_level_dv <= w_dv;
            if (w_dv && !w_gate_move) begin
                r_level <= w_level_nxt;
            end
            if ((w_next_state == c_RELEASE) && (r_state != c_RELEASE)) begin
                r_rel_start <= r_level;
            end
        end
    end

    always_comb begin
        case (r_state)
            c_ATTACK:  bus.env_time = bus.attack_time;
            c_DECAY:   bus.env_time = bus.decay_time;
            c_RELEASE: bus.env_time = bus.release_time;
            default:   bus.env_time = '0;
        endcase
    end

    assign bus.nco_rst      = r_nco_rst;
    assign bus.env_level    = r_level;
    assign bus.env_level_dv = r_level_dv;
    assign bus.env_active   = (r_state != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_adsr_env.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adsr_env
//  Brief    : Directed self-checking bench for the adsr_env envelope sequencer
//  Revision : 1.0  initial release
// ============================================================================
module tb_adsr_env;
    localparam int c_W = 7;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    adsr_env_if #(.W(c_W)) bus ();

    adsr_env #(.W(c_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One NCO sample strobe; outputs reflect it when this returns.
    task automatic dv(input logic [c_W-1:0] scale, input logic ovf);
        bus.env_scale  = scale;
        bus.env_ovflow = ovf;
        bus.env_dv     = 1'b1;
        tick(1);
        bus.env_dv     = 1'b0;
        bus.env_ovflow = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst               = 1'b1;
        bus.gate          = 1'b0;
        bus.attack_time   = 7'd10;
        bus.decay_time    = 7'd20;
        bus.sustain_level = 7'd64;
        bus.release_time  = 7'd30;
        bus.env_scale     = '0;
        bus.env_ovflow    = 1'b0;
        bus.env_dv        = 1'b0;

        // Reset state
        tick(10);
        check("rst_level",    32'(bus.env_level),    0);
        check("rst_level_dv", 32'(bus.env_level_dv), 0);
        check("rst_nco_rst",  32'(bus.nco_rst),      0);
        check("rst_time",     32'(bus.env_time),     0);
        check("rst_active",   32'(bus.env_active),   0);
        rst = 1'b0;
        tick(3);
        check("idle_no_nco_rst", 32'(bus.nco_rst), 0);
        dv(7'd55, 1'b0);
        check("idle_level_dv", 32'(bus.env_level_dv), 1);
        check("idle_level",    32'(bus.env_level),    0);

        // Attack
        bus.gate = 1'b1;
        tick(1);
        check("atk_nco_rst", 32'(bus.nco_rst),    1);
        check("atk_time",    32'(bus.env_time),   10);
        check("atk_active",  32'(bus.env_active), 1);
        tick(1);
        check("atk_nco_rst_1cyc", 32'(bus.nco_rst), 0);
        bus.attack_time = 7'd11;
        #1;
        check("atk_time_live", 32'(bus.env_time), 11);
        dv(7'd0, 1'b0);
        check("atk_lvl0",  32'(bus.env_level),    0);
        check("atk_dv0",   32'(bus.env_level_dv), 1);
        dv(7'd50, 1'b0);
        check("atk_lvl50", 32'(bus.env_level), 50);
        dv(7'd127, 1'b1);
        check("atk_end_lvl",     32'(bus.env_level), 127);
        check("dec_time",        32'(bus.env_time),  20);
        check("dec_nco_rst",     32'(bus.nco_rst),   1);
        tick(1);

        // Decay to 64
        dv(7'd64, 1'b0);
        check("dec_lvl", 32'(bus.env_level), 96);
        dv(7'd127, 1'b1);
        check("dec_end_lvl",  32'(bus.env_level), 64);
        check("sus_time",     32'(bus.env_time),  0);
        check("sus_no_pulse", 32'(bus.nco_rst),   0);
        dv(7'd5, 1'b0);
        check("sus_lvl", 32'(bus.env_level), 64);
        bus.sustain_level = 7'd70;
        dv(7'd9, 1'b0);
        check("sus_live", 32'(bus.env_level), 70);
        bus.sustain_level = 7'd64;
        dv(7'd9, 1'b0);

        // Release from sustain
        bus.gate = 1'b0;
        tick(1);
        check("rel_nco_rst", 32'(bus.nco_rst),  1);
        check("rel_time",    32'(bus.env_time), 30);
        tick(1);
        dv(7'd64, 1'b0);
        check("rel_lvl", 32'(bus.env_level), 32);
        dv(7'd127, 1'b1);
        check("rel_end_lvl",    32'(bus.env_level),  0);
        check("rel_end_active", 32'(bus.env_active), 0);
        check("rel_end_time",   32'(bus.env_time),   0);

        // Release mid-attack, then retrigger in the same cycle as ovflow
        bus.gate = 1'b1;
        tick(2);
        dv(7'd40, 1'b0);
        check("mid_atk_lvl", 32'(bus.env_level), 40);
        bus.gate = 1'b0;
        tick(1);
        check("mid_rel_nco_rst", 32'(bus.nco_rst), 1);
        tick(1);
        dv(7'd64, 1'b0);
        check("mid_rel_lvl", 32'(bus.env_level), 20);
        bus.gate = 1'b1;
        dv(7'd127, 1'b1);
        check("retrig_active",  32'(bus.env_active), 1);
        check("retrig_time",    32'(bus.env_time),   11);
        check("retrig_nco_rst", 32'(bus.nco_rst),    1);
        dv(7'd99, 1'b0);
        check("nco_rst_dv_ignored",  32'(bus.env_level_dv), 0);
        check("nco_rst_lvl_held",    32'(bus.env_level),    20);
        dv(7'd30, 1'b0);
        check("retrig_lvl", 32'(bus.env_level), 30);

        // Zero sustain, then reset mid-decay
        dv(7'd127, 1'b1);
        tick(1);
        bus.sustain_level = 7'd0;
        dv(7'd64, 1'b0);
        check("dec0_lvl", 32'(bus.env_level), 64);
        rst = 1'b1;
        dv(7'd10, 1'b0);
        check("mid_rst_active", 32'(bus.env_active),   0);
        check("mid_rst_level",  32'(bus.env_level),    0);
        check("mid_rst_dv",     32'(bus.env_level_dv), 0);
        dv(7'd10, 1'b0);
        check("mid_rst_dv2",    32'(bus.env_level_dv), 0);
        rst = 1'b0;
        tick(2);

        // Zero-sustain decay runs to 0 and holds
        tick(2);
        dv(7'd127, 1'b1);
        tick(1);
        dv(7'd127, 1'b1);
        check("sus0_end", 32'(bus.env_level), 0);
        dv(7'd80, 1'b0);
        check("sus0_hold",   32'(bus.env_level),  0);
        check("sus0_active", 32'(bus.env_active), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
